pio_in_edge_irq: RTL and testbench
==================================

Name: pio_in_edge_irq

Overview:
- Parametrised successor to the Qsys2 switch PIO input: an Avalon-MM slave that presents a WIDTH-bit external input bus to the Nios II.
- Adds a multi-stage synchroniser, a per-bit debounce filter, a programmable edge-capture register and a maskable level interrupt.
- Sits between board switches/keys and the Qsys interconnect; one instance per input group.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (>=2).
- DEBOUNCE_CYCLES, 1, consecutive cycles a new level must persist before acceptance (>=1; 1 = no debounce).
- EDGE_MODE, 0, captured edge type: 0 rising, 1 falling, 2 any.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- in_port  input  WIDTH  asynchronous external inputs.
- irq  output  1  level interrupt to the processor.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (reset). All flops clear to 0 on reset assertion; operation resumes on the first clk edge after deassertion.
- Reset values: readdata=0, irq=0, sync chain=0, filtered=0, debounce counters=0, irq_mask=0, edge_capture=0.
- Synchroniser:
  - in_port[i] passes through SYNC_STAGES flops; the last stage is s[i].
  - A change sampled at edge k appears on s[i] after edge k+SYNC_STAGES-1.
- Debounce (per bit, counter width clog2(DEBOUNCE_CYCLES+1)):
  - When s[i]==filtered[i], the counter clears to 0.
  - Otherwise the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive edge with s[i]!=filtered[i], filtered[i] takes s[i] and the counter clears.
  - If s[i] reverts first, the counter clears and no change is accepted.
  - With DEBOUNCE_CYCLES=1, filtered is s delayed by one cycle.
- Edge detect:
  - Evaluated on the same edge filtered[i] changes.
  - rise = new 1 with old 0; fall = new 0 with old 1.
  - EDGE_MODE selects rise, fall, or rise|fall.
  - A detected edge sets edge_capture[i] on that edge.
- Write decode: a write occurs when chipselect=1 and write_n=0.
  - Address 2: irq_mask <= writedata[WIDTH-1:0].
  - Address 3: write-1-to-clear; edge_capture[i] clears where writedata[i]=1.
  - Address 0 and address 1: writes ignored.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- Read mux (registered, updated every clk edge regardless of read strobe, zero-extended to 32 bits):
  - Address 0: filtered.
  - Address 1: 0.
  - Address 2: irq_mask.
  - Address 3: edge_capture.
  - Read latency is 1 cycle: readdata reflects the address and register state at the previous edge.
- irq = OR-reduction of (edge_capture & irq_mask). Combinational from registers, glitch-free. Asserts in the cycle after the capturing edge and stays asserted until cleared or masked.
- Total latency from an in_port change (sampled at edge k) to filtered/edge_capture update: edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Readdata shows it one edge later.
- An input held high through reset release produces a rising edge capture once it propagates, because filtered resets to 0. Software clears edge_capture after init.
- Reset mid-debounce discards counter progress. Reset mid-write leaves the target register at its reset value.
- Bits above WIDTH: readdata upper bits always 0; writedata upper bits ignored.

Test Plan:
- Reset and static read (defaults, address=0, in_port=10'h2A5 held 5 cycles after reset) -> readdata=32'h2A5 from the 4th edge on. irq=0 while mask=0. edge_capture reads 32'h2A5 at address 3.
- Rising capture and IRQ (write mask=10'h001, clear capture with 10'h3FF, toggle in_port[0] 0->1) -> edge_capture[0]=1 at edge k+2 and irq=1 after it. Write 1 to addr3 -> irq=0 the next cycle.
- Set-wins collision (W1C of bit 0 in the same cycle bit 0 detects a new edge) -> edge_capture[0] remains 1 and irq stays high.
- Debounce (DEBOUNCE_CYCLES=4): a 3-cycle high pulse on in_port[5] -> filtered[5] stays 0 and no capture. A 6-cycle high pulse -> filtered[5]=1 at edge k+5 and one capture.
- EDGE_MODE=1 and EDGE_MODE=2: in_port[9] 1->0->1 -> mode 1 captures only the fall. Mode 2 captures on both transitions; the bit stays set until cleared.
- Async reset mid-operation (assert reset between edges with capture=10'h3FF, mask=10'h3FF) -> readdata, irq, mask and capture go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/pio_in_edge_irq_if.sv
// pio_in_edge_irq_if: Avalon-MM slave register bus for the edge-capturing PIO input.
// Rev 1.0
`default_nettype none

interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: synchronised, debounced PIO input with edge capture and maskable IRQ.
// Rev 1.0
`default_nettype none

module pio_in_edge_irq #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_MODE       = 0
) (
  input  logic               clk,
  input  logic               reset,
  pio_in_edge_irq_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  localparam int              c_CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_filt;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_mask_we;
  logic [31:0]      w_rd_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        r_sync[j] <= '0;
      end
    end else begin
      r_sync[0] <= in_port;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        r_sync[j] <= r_sync[j-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Per-bit run counter: a new level is accepted on its DEBOUNCE_CYCLES-th consecutive cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if ((w_s[i] == r_filt[i]) || (r_cnt == c_CNT_LAST)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end

    assign w_accept[i] = (w_s[i] != r_filt[i]) && (r_cnt == c_CNT_LAST);
  end

  always_comb begin
    w_det = '0;
    case (EDGE_MODE)
      0:       w_det = w_accept & w_s;
      1:       w_det = w_accept & ~w_s;
      default: w_det = w_accept;
    endcase
  end

  assign w_wr      = bus.chipselect && !bus.write_n;
  assign w_mask_we = w_wr && (bus.address == 2'd2);
  assign w_clr     = (w_wr && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

  if (WIDTH < 32) begin : g_wdata_hi
    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.writedata[31:WIDTH];
  end

  always_comb begin
    w_rd_next = '0;
    case (bus.address)
      2'd0:    w_rd_next[WIDTH-1:0] = r_filt;
      2'd2:    w_rd_next[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_next[WIDTH-1:0] = r_cap;
      default: w_rd_next = '0;
    endcase
  end

  // A new edge outranks a simultaneous write-1-to-clear on the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt     <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_readdata <= '0;
    end else begin
      r_filt     <= r_filt ^ w_accept;
      r_cap      <= (r_cap & ~w_clr) | w_det;
      r_readdata <= w_rd_next;
      if (w_mask_we) begin
        r_mask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = |(r_cap & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: three parameterisations driven in lockstep, checked by table, corner sequences and a reference model.
// Rev 1.0
`default_nettype none

module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  in_port;
  logic [1:0]  addr;
  logic        cs;
  logic        wr_n;
  logic [31:0] wdata;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  pio_in_edge_irq_if bus0 ();
  pio_in_edge_irq_if bus1 ();
  pio_in_edge_irq_if bus2 ();

  assign bus0.address = addr;  assign bus0.chipselect = cs;  assign bus0.write_n = wr_n;  assign bus0.writedata = wdata;
  assign bus1.address = addr;  assign bus1.chipselect = cs;  assign bus1.write_n = wr_n;  assign bus1.writedata = wdata;
  assign bus2.address = addr;  assign bus2.chipselect = cs;  assign bus2.write_n = wr_n;  assign bus2.writedata = wdata;

  pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq0));
  pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq1));
  pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq2));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: accepted level flips when the last DEBOUNCE_CYCLES synchronised samples all differ from it.
  int          m_s [3] = '{2, 2, 3};
  int          m_d [3] = '{1, 4, 4};
  int          m_m [3] = '{0, 1, 2};
  logic [9:0]  hist [16];
  logic [9:0]  m_filt [3];
  logic [9:0]  m_cap [3];
  logic [9:0]  m_mask [3];
  logic [31:0] m_rd [3];

  typedef struct {
    logic [1:0]  a;
    logic        c;
    logic        w;
    logic [31:0] d;
    logic [9:0]  i;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [31:0] rd_of(int u);
    case (u)
      0:       return bus0.readdata;
      1:       return bus1.readdata;
      default: return bus2.readdata;
    endcase
  endfunction

  function automatic logic irq_of(int u);
    case (u)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 16; j++) hist[j] = '0;
    for (int u = 0; u < 3; u++) begin
      m_filt[u] = '0; m_cap[u] = '0; m_mask[u] = '0; m_rd[u] = '0;
    end
  endtask

  task automatic model_edge();
    logic [9:0]  nf, det, clr;
    logic        diff;
    logic [31:0] rdn;
    for (int u = 0; u < 3; u++) begin
      case (addr)
        2'd0:    rdn = {22'b0, m_filt[u]};
        2'd2:    rdn = {22'b0, m_mask[u]};
        2'd3:    rdn = {22'b0, m_cap[u]};
        default: rdn = 32'b0;
      endcase
      nf  = m_filt[u];
      det = '0;
      for (int b = 0; b < 10; b++) begin
        diff = 1'b1;
        for (int t = 0; t < m_d[u]; t++)
          if (hist[m_s[u] - 1 + t][b] == m_filt[u][b]) diff = 1'b0;
        if (diff) begin
          nf[b] = ~m_filt[u][b];
          case (m_m[u])
            0:       det[b] = nf[b];
            1:       det[b] = ~nf[b];
            default: det[b] = 1'b1;
          endcase
        end
      end
      clr = (cs && !wr_n && addr == 2'd3) ? wdata[9:0] : 10'h0;
      m_cap[u] = (m_cap[u] & ~clr) | det;
      if (cs && !wr_n && addr == 2'd2) m_mask[u] = wdata[9:0];
      m_filt[u] = nf;
      m_rd[u]   = rdn;
    end
    for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = in_port;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("model_rd_dut%0d", u), rd_of(u), m_rd[u]);
      check($sformatf("model_irq_dut%0d", u), {31'b0, irq_of(u)}, {31'b0, |(m_cap[u] & m_mask[u])});
    end
  endtask

  task automatic hold(int n);
    cs = 1'b0; wr_n = 1'b1;
    repeat (n) step();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr = a; cs = 1'b1; wr_n = 1'b0; wdata = d;
    step();
    cs = 1'b0; wr_n = 1'b1; wdata = '0;
  endtask

  task automatic read_chk(string name, logic [1:0] a, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    addr = a; cs = 1'b0; wr_n = 1'b1;
    step();
    check({name, "_dut0"}, rd_of(0), e0);
    check({name, "_dut1"}, rd_of(1), e1);
    check({name, "_dut2"}, rd_of(2), e2);
  endtask

  task automatic async_reset_chk(string name);
    #2;
    reset = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s_rd_dut%0d", name, u), rd_of(u), 32'h0);
      check($sformatf("%s_irq_dut%0d", name, u), {31'b0, irq_of(u)}, 32'h0);
    end
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    //            addr  cs    wr_n  wdata         in_port  exp_rd         exp_irq
    tbl[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[1]  = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[2]  = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[3]  = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h2A5,       1'b0};
    tbl[4]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h2A5,       1'b0};
    tbl[5]  = '{2'd2, 1'b1, 1'b0, 32'h001,      10'h2A5, 32'h0,         1'b1};
    tbl[6]  = '{2'd3, 1'b1, 1'b0, 32'h3FF,      10'h2A5, 32'h2A5,       1'b0};
    tbl[7]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A4, 32'h0,         1'b0};
    tbl[8]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[9]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[10] = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b1};
    tbl[11] = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A4, 32'h1,         1'b1};
    tbl[12] = '{2'd3, 1'b1, 1'b0, 32'h1,        10'h2A5, 32'h1,         1'b0};
    tbl[13] = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[14] = '{2'd3, 1'b1, 1'b0, 32'h1,        10'h2A5, 32'h0,         1'b1};
    tbl[15] = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h1,         1'b1};
    tbl[16] = '{2'd1, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b1};
    tbl[17] = '{2'd2, 1'b1, 1'b0, 32'h0,        10'h2A5, 32'h1,         1'b0};
    tbl[18] = '{2'd2, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h0,         1'b0};
    tbl[19] = '{2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 10'h2A5, 32'h2A5,       1'b0};
    tbl[20] = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 10'h2A5, 32'h0,         1'b1};
    tbl[21] = '{2'd2, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h3FF,       1'b1};

    reset = 1'b1; addr = '0; cs = 1'b0; wr_n = 1'b1; wdata = '0; in_port = 10'h2A5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset_rd_dut%0d", u), rd_of(u), 32'h0);
      check($sformatf("reset_irq_dut%0d", u), {31'b0, irq_of(u)}, 32'h0);
    end
    #3;
    reset = 1'b0;

    for (int r = 0; r < 22; r++) begin
      addr = tbl[r].a; cs = tbl[r].c; wr_n = tbl[r].w; wdata = tbl[r].d; in_port = tbl[r].i;
      step();
      check($sformatf("tbl%0d_rd", r), rd_of(0), tbl[r].er);
      check($sformatf("tbl%0d_irq", r), {31'b0, irq0}, {31'b0, tbl[r].ei});
    end
    cs = 1'b0; wr_n = 1'b1;

    // Quiesce, clear captures, unmask everything.
    in_port = 10'h000;
    hold(12);
    wr(2'd3, 32'hFFFFFFFF);
    wr(2'd2, 32'h3FF);

    // Short pulse is rejected by the 4-cycle filters; long pulse is accepted.
    in_port = 10'h020; hold(3);
    in_port = 10'h000; hold(12);
    read_chk("short_pulse_filt", 2'd0, 32'h0, 32'h0, 32'h0);
    read_chk("short_pulse_cap", 2'd3, 32'h20, 32'h0, 32'h0);
    wr(2'd3, 32'hFFFFFFFF);
    in_port = 10'h020; hold(10);
    read_chk("long_pulse_filt", 2'd0, 32'h20, 32'h20, 32'h20);
    in_port = 10'h000; hold(12);
    read_chk("long_pulse_cap", 2'd3, 32'h20, 32'h20, 32'h20);

    // Edge mode selection on bit 9.
    wr(2'd3, 32'hFFFFFFFF);
    in_port = 10'h200; hold(12);
    wr(2'd3, 32'hFFFFFFFF);
    in_port = 10'h000; hold(12);
    read_chk("fall_cap", 2'd3, 32'h0, 32'h200, 32'h200);
    in_port = 10'h200; hold(12);
    read_chk("rise_cap", 2'd3, 32'h200, 32'h200, 32'h200);

    // Full capture with full mask, then asynchronous reset between edges.
    in_port = 10'h3FF; hold(12);
    read_chk("full_cap", 2'd3, 32'h3FF, 32'h200, 32'h3FF);
    async_reset_chk("async_reset");
    read_chk("post_reset_mask", 2'd2, 32'h0, 32'h0, 32'h0);
    read_chk("post_reset_cap", 2'd3, 32'h0, 32'h0, 32'h0);

    for (int n = 0; n < 800; n++) begin
      addr  = 2'($urandom_range(0, 3));
      cs    = ($urandom_range(0, 3) == 0);
      wr_n  = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ 10'(1 << $urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0) in_port = 10'($urandom);
      step();
      if ($urandom_range(0, 199) == 0) async_reset_chk("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
